// File: rtl/morse_round_ctrl.sv
// Session/round sequencer for the Morse trainer: letter request, decoder arming, scoring, pacing.
// Build option: define MORSE_TIMEOUT_EN to give the ARMED state a tick-based forced-fail timeout.
module morse_round_ctrl #(
    parameter int NUM_ROUNDS    = 8,
    parameter int CNT_W         = 4,
    parameter int TMR_W         = 8,
    parameter int TIMEOUT_TICKS = 200,
    parameter int GAP_TICKS     = 50
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             start_i,
    output logic             letter_req_o,
    input  logic             letter_ready_i,
    output logic             decode_en_o,
    input  logic             decode_done_i,
    input  logic             decode_correct_i,
    output logic             result_valid_o,
    output logic             result_pass_o,
    output logic [CNT_W-1:0] round_o,
    output logic [CNT_W-1:0] score_o,
    output logic             session_done_o,
    output logic [2:0]       state_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REQ      = 3'd1;
    localparam logic [2:0] S_WAIT_RDY = 3'd2;
    localparam logic [2:0] S_ARMED    = 3'd3;
    localparam logic [2:0] S_RESULT   = 3'd4;
    localparam logic [2:0] S_GAP      = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    localparam logic [CNT_W-1:0] ROUNDS_LAST = CNT_W'(NUM_ROUNDS);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [TMR_W-1:0] GAP_LAST    = TMR_W'(GAP_TICKS);
`ifdef MORSE_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(TIMEOUT_TICKS - 1);
`endif

    // Reject configurations whose limits do not fit the counter widths.
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > (2 ** CNT_W) - 1) begin : g_bad_rounds
        $error("morse_round_ctrl: NUM_ROUNDS does not fit CNT_W");
    end
    if (TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > (2 ** TMR_W) - 1) begin : g_bad_timeout
        $error("morse_round_ctrl: TIMEOUT_TICKS does not fit TMR_W");
    end
    if (GAP_TICKS < 0 || GAP_TICKS > (2 ** TMR_W) - 1) begin : g_bad_gap
        $error("morse_round_ctrl: GAP_TICKS does not fit TMR_W");
    end

    logic [2:0]       state;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] round_q;
    logic [CNT_W-1:0] score_q;
    logic             pass_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            timer   <= '0;
            round_q <= '0;
            score_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state   <= S_REQ;
                        timer   <= '0;
                        round_q <= '0;
                        score_q <= '0;
                        pass_q  <= 1'b0;
                    end
                end
                S_REQ: begin
                    state <= start_i ? S_WAIT_RDY : S_IDLE;
                end
                S_WAIT_RDY: begin
                    if (!start_i) begin
                        state <= S_IDLE;
                    end else if (letter_ready_i) begin
                        state <= S_ARMED;
                        timer <= '0;
                    end
                end
                // A verdict on the same cycle as the final tick beats the timeout.
                S_ARMED: begin
                    if (!start_i) begin
                        state <= S_IDLE;
                    end else if (decode_done_i) begin
                        state  <= S_RESULT;
                        pass_q <= decode_correct_i;
                    end
`ifdef MORSE_TIMEOUT_EN
                    else if (tick_i && timer == TMO_LAST) begin
                        state  <= S_RESULT;
                        pass_q <= 1'b0;
                    end else if (tick_i) begin
                        timer <= timer + 1'b1;
                    end
`endif
                end
                S_RESULT: begin
                    if (!start_i) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_GAP;
                        timer <= '0;
                        if (round_q != CNT_MAX) begin
                            round_q <= round_q + 1'b1;
                        end
                        if (pass_q && score_q != CNT_MAX) begin
                            score_q <= score_q + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (!start_i) begin
                        state <= S_IDLE;
                    end else if (timer == GAP_LAST) begin
                        state <= (round_q == ROUNDS_LAST) ? S_DONE : S_REQ;
                    end else if (tick_i) begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!start_i) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign letter_req_o   = (state == S_REQ);
    assign decode_en_o    = (state == S_ARMED);
    assign result_valid_o = (state == S_RESULT);
    assign session_done_o = (state == S_DONE);
    assign result_pass_o  = pass_q;
    assign round_o        = round_q;
    assign score_o        = score_q;
    assign state_o        = state;

endmodule
